// File: rtl/i2s_frame_seq.sv
// Ping-pong frame sequencer: captures I2S samples into two FRAME_LEN banks and streams full banks out.
// Optional receiver-stall detection is built when I2S_TIMEOUT_EN is defined.
module i2s_frame_seq #(
  parameter int unsigned FRAME_LEN   = 16,
  parameter int unsigned TIMEOUT_CYC = 8192
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] sample,
  input  logic        sample_valid,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        overrun,
  output logic [7:0]  ovr_count,
  output logic        timeout
);

  localparam int unsigned IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  state_t        state;
  logic [15:0]   mem [2][FRAME_LEN];
  logic [1:0]    full;
  logic [1:0]    full_nxt;
  logic          wr_bank;
  logic          rd_bank;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic [IW-1:0] rd_idx_inc;

  logic accept_start;
  logic wr_en;
  logic drop;
  logic wr_fill;
  logic rd_done;

  always_comb begin
    accept_start = (state == IDLE) && start && !stop;
    wr_en        = (state == CAPTURE) && !stop && sample_valid && !full[wr_bank];
    drop         = (state == CAPTURE) && !stop && sample_valid && full[wr_bank];
    wr_fill      = wr_en && (wr_idx == LAST_IDX);
    rd_done      = out_valid && out_ready && (rd_idx == LAST_IDX);
    rd_idx_inc   = rd_idx + IW'(1);
    // Fill and drain of opposite banks in one cycle must both land.
    full_nxt = full;
    if (rd_done) full_nxt[rd_bank] = 1'b0;
    if (wr_fill) full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank][wr_idx] <= sample;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      full      <= 2'b00;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      overrun   <= 1'b0;
      ovr_count <= '0;
    end else begin
      full <= full_nxt;

      case (state)
        IDLE: begin
          if (accept_start) begin
            state <= CAPTURE;
            busy  <= 1'b1;
          end
        end
        CAPTURE: begin
          if (stop) begin
            state  <= DRAIN;
            wr_idx <= '0;
          end else if (wr_en) begin
            if (wr_idx == LAST_IDX) begin
              wr_idx  <= '0;
              wr_bank <= ~wr_bank;
            end else begin
              wr_idx <= wr_idx + IW'(1);
            end
          end
        end
        DRAIN: begin
          if ((full == 2'b00) && !out_valid) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (accept_start) begin
        overrun   <= 1'b0;
        ovr_count <= '0;
      end else if (drop) begin
        overrun <= 1'b1;
        if (ovr_count != 8'hFF) ovr_count <= ovr_count + 8'd1;
      end

      // Read side: present word rd_idx of the oldest full bank, advance on handshake.
      if (out_valid) begin
        if (out_ready) begin
          if (rd_idx == LAST_IDX) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            rd_idx    <= '0;
            rd_bank   <= ~rd_bank;
          end else begin
            rd_idx   <= rd_idx_inc;
            out_data <= mem[rd_bank][rd_idx_inc];
            out_last <= (rd_idx_inc == LAST_IDX);
          end
        end
      end else if (full[rd_bank]) begin
        out_valid <= 1'b1;
        out_data  <= mem[rd_bank][0];
        out_last  <= (LAST_IDX == '0);
      end
    end
  end

`ifdef I2S_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;
  logic          to_flag;

  // Cycles in CAPTURE since the last sample strobe; saturates at TIMEOUT_CYC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else if (accept_start) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else if (state == CAPTURE) begin
      if (sample_valid) begin
        to_cnt <= '0;
      end else if (to_cnt != TW'(TIMEOUT_CYC)) begin
        to_cnt <= to_cnt + TW'(1);
        if (to_cnt == TW'(TIMEOUT_CYC - 1)) to_flag <= 1'b1;
      end
    end
  end

  assign timeout = to_flag;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_frame_seq.sv
// Bench for i2s_frame_seq: directed scenarios plus randomized traffic against a frame-queue model.
module tb_i2s_frame_seq;

  localparam int FL = 4;
  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, sv, ready;
  logic [15:0] sample;
  logic [15:0] out_data;
  logic        out_valid, out_last, busy, overrun, timeout;
  logic [7:0]  ovr_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: completed frames as a flat word queue, partial frame, flags.
  int          m_state;   // 0 idle, 1 capture, 2 drain
  logic [15:0] frames[$];
  logic [15:0] partial[$];
  int          k;
  int          m_ovr;
  bit          m_ovf;
  bit          m_to;
  int          m_tocnt;
  int          wait_cyc;
  bit          prev_hold;
  logic [15:0] prev_data;
  logic        prev_last;
  logic [15:0] acc_log[$];
  logic        last_log[$];

  i2s_frame_seq #(.FRAME_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .sample(sample), .sample_valid(sv),
    .out_data(out_data), .out_valid(out_valid), .out_ready(ready),
    .out_last(out_last), .busy(busy), .overrun(overrun),
    .ovr_count(ovr_count), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_state = 0; frames.delete(); partial.delete(); k = 0;
    m_ovr = 0; m_ovf = 0; m_to = 0; m_tocnt = 0; wait_cyc = 0; prev_hold = 0;
  endtask

  // One clock: drive inputs at negedge, check outputs, advance model to the next posedge.
  task automatic step(input bit st, input bit sp, input bit v, input logic [15:0] d, input bit rdy);
    int nfull;
    bit exp_to;
    logic [15:0] exp_d;
    @(negedge clk);
    start = st; stop = sp; sv = v; sample = d; ready = rdy;
`ifdef I2S_TIMEOUT_EN
    exp_to = m_to;
`else
    exp_to = 1'b0;
`endif
    n_tests++;
    if (busy !== (m_state != 0)) begin n_fail++; $display("FAIL busy: got %0b expected %0b", busy, m_state != 0); end
    n_tests++;
    if (overrun !== m_ovf || ovr_count !== 8'(m_ovr)) begin
      n_fail++; $display("FAIL ovr_flags: got %0b/%0d expected %0b/%0d", overrun, ovr_count, m_ovf, m_ovr);
    end
    n_tests++;
    if (timeout !== exp_to) begin n_fail++; $display("FAIL timeout: got %0b expected %0b", timeout, exp_to); end
    if (prev_hold) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
        n_fail++; $display("FAIL hold: got v=%0b d=%0h l=%0b expected v=1 d=%0h l=%0b",
                           out_valid, out_data, out_last, prev_data, prev_last);
      end
    end

    nfull = (frames.size() + k) / FL;
    if (nfull > 0 && out_valid !== 1'b1) wait_cyc++; else wait_cyc = 0;
    if (wait_cyc > 2) begin
      n_tests++; n_fail++; wait_cyc = 0;
      $display("FAIL latency: out_valid low 3 cycles with %0d full banks", nfull);
    end

    if (out_valid === 1'b1 && rdy) begin
      n_tests++;
      if (frames.size() == 0) begin
        n_fail++; $display("FAIL spurious_out: got data %0h expected no transfer", out_data);
      end else begin
        exp_d = frames.pop_front();
        if (out_data !== exp_d || out_last !== (k == FL - 1)) begin
          n_fail++; $display("FAIL stream: got %0h last=%0b expected %0h last=%0b",
                             out_data, out_last, exp_d, k == FL - 1);
        end
        k = (k + 1) % FL;
      end
      acc_log.push_back(out_data);
      last_log.push_back(out_last);
    end
    prev_hold = (out_valid === 1'b1) && !rdy;
    prev_data = out_data;
    prev_last = out_last;

    case (m_state)
      0: if (st && !sp) begin m_state = 1; m_ovr = 0; m_ovf = 0; m_to = 0; m_tocnt = 0; end
      1: begin
        if (v) m_tocnt = 0;
        else if (m_tocnt < TO) begin m_tocnt++; if (m_tocnt == TO) m_to = 1; end
        if (sp) begin
          partial.delete(); m_state = 2;
        end else if (v) begin
          if (nfull == 2) begin m_ovf = 1; if (m_ovr < 255) m_ovr++; end
          else begin
            partial.push_back(d);
            if (partial.size() == FL) begin
              foreach (partial[i]) frames.push_back(partial[i]);
              partial.delete();
            end
          end
        end
      end
      default: if (nfull == 0) m_state = 0;
    endcase
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (busy === 1'b0 && m_state == 0) break;
      step(0, 0, 0, 16'h0, 1);
    end
    n_tests++;
    if (busy !== 1'b0 || m_state != 0) begin n_fail++; $display("FAIL idle_bound: got busy=%0b expected 0", busy); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; stop = 0; sv = 0; sample = '0; ready = 0;
    model_clear();
    repeat (3) @(negedge clk);
    n_tests++;
    if ({out_valid, out_last, busy, overrun, timeout} !== 5'b0 || out_data !== 16'h0 || ovr_count !== 8'h0) begin
      n_fail++; $display("FAIL reset_state: got v=%0b l=%0b b=%0b o=%0b t=%0b d=%0h c=%0d expected all 0",
                         out_valid, out_last, busy, overrun, timeout, out_data, ovr_count);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [15:0] exp_d[4];
    logic        exp_l[4];
    exp_d = '{16'h1, 16'h2, 16'h3, 16'h4};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
    acc_log.delete(); last_log.delete();
    step(1, 0, 0, 16'h0, 1);
    for (int i = 1; i <= 4; i++) step(0, 0, 1, 16'(i), 1);
    repeat (8) step(0, 0, 0, 16'h0, 1);
    n_tests++;
    if (acc_log.size() != 4) begin n_fail++; $display("FAIL basic_count: got %0d expected 4", acc_log.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (acc_log[i] !== exp_d[i] || last_log[i] !== exp_l[i]) begin
        n_fail++; $display("FAIL basic_word%0d: got %0h/%0b expected %0h/%0b", i, acc_log[i], last_log[i], exp_d[i], exp_l[i]);
      end
    end
    n_tests++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL basic_overrun: got %0b expected 0", overrun); end
    step(0, 1, 0, 16'h0, 1);
    wait_idle();
  endtask

  task automatic test_overrun();
    acc_log.delete();
    step(1, 0, 0, 16'h0, 0);
    for (int i = 1; i <= 12; i++) step(0, 0, 1, 16'(i), 0);
    repeat (3) step(0, 0, 0, 16'h0, 0);
    n_tests++;
    if (overrun !== 1'b1 || ovr_count !== 8'd4) begin
      n_fail++; $display("FAIL ovr_directed: got %0b/%0d expected 1/4", overrun, ovr_count);
    end
    repeat (16) step(0, 0, 0, 16'h0, 1);
    n_tests++;
    if (acc_log.size() != 8) begin n_fail++; $display("FAIL ovr_count_out: got %0d expected 8", acc_log.size()); end
    else for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (acc_log[i] !== 16'(i + 1)) begin n_fail++; $display("FAIL ovr_word%0d: got %0h expected %0h", i, acc_log[i], i + 1); end
    end
    step(0, 1, 0, 16'h0, 1);
    wait_idle();
  endtask

  task automatic test_drain();
    acc_log.delete();
    step(1, 0, 0, 16'h0, 0);
    for (int i = 1; i <= 6; i++) step(0, 0, 1, 16'(i), 0);
    step(0, 1, 0, 16'h0, 0);
    wait_idle();
    n_tests++;
    if (acc_log.size() != 4) begin n_fail++; $display("FAIL drain_count: got %0d expected 4", acc_log.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (acc_log[i] !== 16'(i + 1)) begin n_fail++; $display("FAIL drain_word%0d: got %0h expected %0h", i, acc_log[i], i + 1); end
    end
    repeat (3) step(0, 0, 0, 16'h0, 1);
    n_tests++;
    if (busy !== 1'b0 || acc_log.size() != 4) begin
      n_fail++; $display("FAIL drain_idle: got busy=%0b words=%0d expected 0/4", busy, acc_log.size());
    end
  endtask

  task automatic test_start_stop();
    step(1, 1, 0, 16'h0, 1);
    step(0, 0, 1, 16'h55, 1);
    step(0, 0, 0, 16'h0, 1);
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL start_stop: got busy=%0b expected 0", busy); end
  endtask

  task automatic test_timeout();
    bit exp_to;
`ifdef I2S_TIMEOUT_EN
    exp_to = 1'b1;
`else
    exp_to = 1'b0;
`endif
    step(1, 0, 0, 16'h0, 1);
    repeat (TO + 5) step(0, 0, 0, 16'h0, 1);
    n_tests++;
    if (timeout !== exp_to) begin n_fail++; $display("FAIL timeout_set: got %0b expected %0b", timeout, exp_to); end
    step(0, 1, 0, 16'h0, 1);
    wait_idle();
    step(1, 0, 0, 16'h0, 1);
    step(0, 0, 0, 16'h0, 1);
    n_tests++;
    if (timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: got %0b expected 0", timeout); end
    step(0, 1, 0, 16'h0, 1);
    wait_idle();
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      step(1, 0, 0, 16'h0, 1);
      for (int i = 0; i < 200; i++)
        step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 55,
             16'($urandom), $urandom_range(0, 99) < 50);
      step(0, 1, 0, 16'h0, 1);
      wait_idle();
      n_tests++;
      if (frames.size() != 0) begin n_fail++; $display("FAIL rand_residue: got %0d words left expected 0", frames.size()); end
    end
  endtask

  task automatic test_reset_mid();
    step(1, 0, 0, 16'h0, 0);
    for (int i = 1; i <= 4; i++) step(0, 0, 1, 16'(16'h100 + i), 0);
    repeat (2) step(0, 0, 0, 16'h0, 0);
    n_tests++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid: got %0b expected 1", out_valid); end
    @(negedge clk);
    rst_n = 1'b0; ready = 1'b1; start = 0; stop = 0; sv = 0;
    #1;
    n_tests++;
    if ({out_valid, out_last, busy, overrun} !== 4'b0 || out_data !== 16'h0) begin
      n_fail++; $display("FAIL mid_reset: got v=%0b l=%0b b=%0b d=%0h expected all 0", out_valid, out_last, busy, out_data);
    end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) step(0, 0, 1, 16'hABCD, 1);
    n_tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL post_reset: got busy=%0b valid=%0b expected 0/0", busy, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_drain();
    test_start_stop();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
